bin32_to_bcd: RTL and testbench
===============================

# bin32_to_bcd

Sequential binary-to-BCD converter: converts a 32-bit unsigned binary value into eight packed BCD digits using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits beside the UART I/O block and supplies the decimal digits for decimal-text transmission, which sends the most significant non-zero digit first. A start/done handshake replaces combinational conversion, keeping the logic depth to one digit-adjust stage per cycle.

## Interface
- Parameters: none. The input is fixed at 32 bits and the output at 8 digits.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled on a clock edge while idle.
- bin  input  32  unsigned binary operand; captured only on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd and overflow update.
- bcd  output  32  packed BCD result; bits [31:28] hold the most significant digit and bits [3:0] the least significant digit.
- overflow  output  1  high when the captured operand is greater than 99_999_999.

## Operation
- States:
  - IDLE: busy is low. When start is high, capture bin into the shift register, clear the 8-digit working register, clear the bit counter to 0, go to SHIFT, and raise busy.
  - SHIFT: each cycle performs two steps.
    - First, every working digit that is 5 or greater has 3 added to it.
    - Second, {working, shift} is shifted left by 1. The MSB of the shift register enters working bit 0, and the carry out of the top digit is discarded.
    - After the 32nd shift, go to DONE.
  - DONE: load bcd from the working register, load overflow, pulse done, drop busy, and return to IDLE.
- Truncation: dropping the top-digit carry makes bcd equal to the operand mod 10^8. The lower digits are exact.
- overflow is computed at capture time as (bin > 32'd99_999_999) and is held in a register until DONE.
- bcd and overflow hold their values between conversions. They do not change during SHIFT.
- start is ignored while busy is high. There is no queueing.
- start asserted in the DONE cycle is ignored. It is accepted on the next edge, once the block is in IDLE.
- bin may change freely after the capture edge.

## Timing
- Reset (asynchronous, rst_n=0): state returns to IDLE. busy=0, done=0, bcd=32'h0, overflow=0. The working registers and counter are cleared.
- Reset during SHIFT aborts the conversion. No done pulse is produced.
- Latency: start accepted at edge E. Shifts happen at edges E+1 through E+32. bcd, overflow and done become valid after edge E+33. done is high for exactly one cycle.
- busy is high from after edge E until after edge E+33. busy and done are never high at the same time.
- Throughput: one conversion every 34 cycles at most.

## Structure
- Shared package holds:
  - BCD_DIGITS = 8
  - BIN_WIDTH = 32
  - BCD_MAX = 32'd99_999_999
  - the state enum {IDLE, SHIFT, DONE}
- Sub-module bcd_digit_adj: combinational, 4 bits in and 4 bits out. It adds 3 when the input is 5 or greater. The converter instantiates it 8 times with a generate loop.
- Control: a 6-bit bit counter and a 2-bit state register.

## Test plan
- bin=0, start pulse -> done after 33 edges, bcd=32'h00000000, overflow=0.
- bin=12_345_678 -> bcd=32'h12345678, overflow=0. Also bin=99_999_999 -> bcd=32'h99999999, overflow=0.
- bin=100_000_000 -> bcd=32'h00000000, overflow=1. Also bin=32'hFFFFFFFF (4_294_967_295) -> bcd=32'h94967295, overflow=1.
- Start bin=5, then pulse start with bin=7 at the 10th cycle of busy -> the second request is ignored. bcd=32'h00000005, exactly one done pulse.
- Assert rst_n=0 mid-conversion -> busy, done, bcd and overflow are 0 immediately. No done pulse. A fresh start with bin=42 yields bcd=32'h00000042.
- Random sweep of 1000 values -> bcd matches the reference decimal digits mod 10^8. overflow matches the comparison against 99_999_999. Latency is always 33 edges.

Source files
------------

// File: rtl/bin32_to_bcd_pkg.sv
// Shared constants and state encoding for the 32-bit binary to 8-digit BCD converter.
package bin32_to_bcd_pkg;

    localparam int BCD_DIGITS = 8;
    localparam int BIN_WIDTH  = 32;
    localparam int BCD_WIDTH  = 4 * BCD_DIGITS;
    localparam int CNT_WIDTH  = 6;

    localparam logic [BIN_WIDTH-1:0] BCD_MAX   = 32'd99_999_999;
    localparam logic [CNT_WIDTH-1:0] LAST_SHIFT = CNT_WIDTH'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin32_to_bcd_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj (
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/bin32_to_bcd.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock with a start/done handshake.
// Result is the operand mod 10^8; overflow flags operands above 99_999_999.
module bin32_to_bcd
    import bin32_to_bcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_WIDTH-1:0] bcd,
    output logic                 overflow
);

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [BIN_WIDTH-1:0]   r_shift;
    logic [BCD_WIDTH-1:0]   r_work;
    logic                   r_ovf_cap;
    logic                   r_busy;
    logic                   r_done;
    logic [BCD_WIDTH-1:0]   r_bcd;
    logic                   r_ovf;

    logic [BCD_WIDTH-1:0]   w_adj;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_dig (r_work[4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    // The top digit's carry falls off the end of the shift, which is what yields mod 10^8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_work    <= '0;
            r_ovf_cap <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_work    <= '0;
                        r_cnt     <= '0;
                        r_ovf_cap <= (bin > BCD_MAX);
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work  <= {w_adj[BCD_WIDTH-2:0], r_shift[BIN_WIDTH-1]};
                    r_shift <= {r_shift[BIN_WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_SHIFT)
                        r_state <= DONE;
                end
                DONE: begin
                    r_bcd   <= r_work;
                    r_ovf   <= r_ovf_cap;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin32_to_bcd.sv
// Randomized self-checking bench for bin32_to_bcd against an arithmetic decimal-digit model.
module tb_bin32_to_bcd;

    localparam logic [31:0] MAXV = 32'd99_999_999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bin = '0;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    bin32_to_bcd dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Decimal digits of v mod 10^8, least significant digit in the low nibble.
    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        longint x;
        logic [31:0] r;
        x = longint'(v) % 100000000;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic run_conv(input logic [31:0] v);
        int lat;
        logic [31:0] prev;
        prev = bcd;
        lat  = 0;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = $urandom;
        chk("busy_on", 32'(busy), 32'd1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 16) chk("bcd_hold", bcd, prev);
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd33);
        chk("bcd", bcd, ref_bcd(v));
        chk("overflow", 32'(overflow), 32'(v > MAXV));
        chk("busy_off", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int ndone;
        int lat;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", bcd, 32'h0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_conv(32'd0);
        chk("bcd_zero_const", bcd, 32'h00000000);
        run_conv(32'd12_345_678);
        chk("bcd_12345678_const", bcd, 32'h12345678);
        run_conv(32'd99_999_999);
        chk("bcd_max_const", bcd, 32'h99999999);
        run_conv(32'd100_000_000);
        chk("ovf_100m_const", 32'(overflow), 32'd1);
        run_conv(32'hFFFF_FFFF);
        chk("bcd_ffff_const", bcd, 32'h94967295);

        // Abort mid-conversion; outputs currently hold 94967295 / overflow=1.
        @(negedge clk);
        bin   = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_bcd", bcd, 32'h0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        run_conv(32'd42);
        chk("bcd_42_const", bcd, 32'h00000042);

        // Second start while busy must be dropped.
        @(negedge clk);
        bin   = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        lat   = 0;
        for (int n = 1; n <= 45; n++) begin
            if (n == 10) begin
                bin   = 32'd7;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            if (n == 10) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
            end
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_lat", 32'(lat), 32'd33);
        chk("ign_bcd", bcd, 32'h00000005);
        chk("ign_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 99_999_999);
                2: v = MAXV - 32'd8 + 32'($urandom_range(0, 16));
                default: v = $urandom_range(0, 999);
            endcase
            run_conv(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
